// File: rtl/mem_bridge.sv
// mem_bridge: serialises ICache line refills and DCache word accesses
// onto one word-wide req/ack memory bus.
module mem_bridge #(
  parameter int WORD       = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ic_valid,
  input  logic [WORD-1:0]            ic_addr,
  output logic                       ic_ready,
  output logic [WORD*LINE_WORDS-1:0] ic_line,
  input  logic                       dc_valid,
  input  logic                       dc_we,
  input  logic [WORD-1:0]            dc_addr,
  input  logic [WORD-1:0]            dc_wdata,
  input  logic [3:0]                 dc_wstrb,
  output logic                       dc_ready,
  output logic [WORD-1:0]            dc_rdata,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [WORD-1:0]            mem_addr,
  output logic [WORD-1:0]            mem_wdata,
  output logic [3:0]                 mem_wstrb,
  input  logic                       mem_ack,
  input  logic [WORD-1:0]            mem_rdata
);

  localparam int BYTES = WORD / 8;
  localparam int CW    = $clog2(LINE_WORDS);
  localparam int BOFF  = $clog2(BYTES);
  localparam logic [WORD-1:0] W_MASK =
    WORD'(BYTES - 1);
  localparam logic [WORD-1:0] L_MASK =
    WORD'(BYTES * LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IC_BURST,
    S_IC_RESP,
    S_DC_ACC,
    S_DC_RESP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CW-1:0]            r_cnt;
  logic [CW-1:0]            w_cnt_inc;
  logic                     w_ack;
  logic                     w_last;
  logic                     r_ic_ready;
  logic                     r_dc_ready;
  logic [WORD*LINE_WORDS-1:0] r_ic_line;
  logic [WORD-1:0]          r_dc_rdata;
  logic                     r_mem_req;
  logic                     r_mem_we;
  logic [WORD-1:0]          r_mem_addr;
  logic [WORD-1:0]          r_mem_wdata;
  logic [3:0]               r_mem_wstrb;

  // acks are only meaningful while a request is outstanding
  assign w_ack     = mem_ack & r_mem_req;
  assign w_last    = (r_cnt == CW'(LINE_WORDS - 1));
  assign w_cnt_inc = r_cnt + CW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (dc_valid)      w_state_nxt = S_DC_ACC;
        else if (ic_valid) w_state_nxt = S_IC_BURST;
      end
      S_IC_BURST: begin
        if (w_ack && w_last) w_state_nxt = S_IC_RESP;
      end
      S_IC_RESP: w_state_nxt = S_IDLE;
      S_DC_ACC: begin
        if (w_ack) w_state_nxt = S_DC_RESP;
      end
      S_DC_RESP: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_ic_ready  <= 1'b0;
      r_dc_ready  <= 1'b0;
      r_ic_line   <= '0;
      r_dc_rdata  <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= 4'b0000;
    end else begin
      r_mem_req  <= (w_state_nxt == S_IC_BURST) ||
                    (w_state_nxt == S_DC_ACC);
      r_ic_ready <= (w_state_nxt == S_IC_RESP);
      r_dc_ready <= (w_state_nxt == S_DC_RESP);
      unique case (r_state)
        S_IDLE: begin
          if (dc_valid) begin
            r_mem_we    <= dc_we;
            r_mem_addr  <= dc_addr & ~W_MASK;
            r_mem_wdata <= dc_wdata;
            r_mem_wstrb <= dc_we ? dc_wstrb : 4'b0000;
          end else if (ic_valid) begin
            r_cnt       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= ic_addr & ~L_MASK;
            r_mem_wdata <= '0;
            r_mem_wstrb <= 4'b0000;
          end
        end
        S_IC_BURST: begin
          if (w_ack) begin
            r_ic_line[int'(r_cnt)*WORD +: WORD] <= mem_rdata;
            r_cnt <= w_cnt_inc;
            // beat index replaces the in-line word bits: no carry out
            r_mem_addr <= {r_mem_addr[WORD-1:BOFF+CW],
                           w_cnt_inc, {BOFF{1'b0}}};
          end
        end
        S_DC_ACC: begin
          if (w_ack && !r_mem_we) r_dc_rdata <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  assign ic_ready  = r_ic_ready;
  assign ic_line   = r_ic_line;
  assign dc_ready  = r_dc_ready;
  assign dc_rdata  = r_dc_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;

endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge: table vectors plus hand sequences, with a bus
// responder and queues of expected transfers and responses.
module tb_mem_bridge;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ic_valid = 1'b0;
  logic [31:0]  ic_addr = '0;
  logic         ic_ready;
  logic [127:0] ic_line;
  logic         dc_valid = 1'b0;
  logic         dc_we = 1'b0;
  logic [31:0]  dc_addr = '0;
  logic [31:0]  dc_wdata = '0;
  logic [3:0]   dc_wstrb = '0;
  logic         dc_ready;
  logic [31:0]  dc_rdata;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [3:0]   mem_wstrb;
  logic         mem_ack = 1'b0;
  logic [31:0]  mem_rdata = '0;

  mem_bridge #(.WORD(32), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst),
    .ic_valid(ic_valid), .ic_addr(ic_addr),
    .ic_ready(ic_ready), .ic_line(ic_line),
    .dc_valid(dc_valid), .dc_we(dc_we),
    .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_wstrb(dc_wstrb), .dc_ready(dc_ready),
    .dc_rdata(dc_rdata),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           dc;
    bit           we;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    int           dly;
    int           lat;
    logic [127:0] xdat;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_t;

  bus_t         bus_q[$];
  logic [127:0] ic_q[$];
  logic [31:0]  dc_q[$];
  logic [31:0]  bus_mem[logic [31:0]];
  vec_t         vecs[8];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ack_delay = 0;
  int wait_cnt = 0;
  bit stray = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (bus_mem.exists(a)) return bus_mem[a];
    return a + 32'h100;
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    logic [31:0] v;
    v = rd(a);
    for (int b = 0; b < 4; b++)
      if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    bus_mem[a] = v;
  endtask

  // memory responder: ack after ack_delay idle cycles per transfer
  initial forever begin
    @(posedge clk);
    #2;
    if (stray) begin
      mem_ack = 1'b1;
      mem_rdata = 32'hBAD0BAD0;
    end else if (rst && mem_req) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack = 1'b1;
        mem_rdata = mem_we ? 32'h0 : rd(mem_addr);
        if (mem_we) wr(mem_addr, mem_wdata, mem_wstrb);
        wait_cnt = 0;
      end else begin
        mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  // monitor: transfers, stability, responses, overlap
  initial begin
    bit          pend;
    logic [68:0] prev;
    bus_t        e;
    pend = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst && mem_req && mem_ack) begin
        if (bus_q.size() == 0) begin
          chk("bus_extra", {mem_we, mem_addr}, '0);
        end else begin
          e = bus_q.pop_front();
          chk("bus_addr", mem_addr, e.addr);
          chk("bus_we", mem_we, e.we);
          chk("bus_wstrb", mem_wstrb, e.wstrb);
          if (e.we) chk("bus_wdata", mem_wdata, e.wdata);
        end
      end
      if (pend && rst && mem_req)
        chk("bus_stable",
            {mem_we, mem_addr, mem_wdata, mem_wstrb}, prev);
      pend = rst && mem_req && !mem_ack;
      prev = {mem_we, mem_addr, mem_wdata, mem_wstrb};
      if (ic_ready) begin
        if (ic_q.size() == 0) chk("ic_extra", ic_line, '0);
        else chk("ic_line", ic_line, ic_q.pop_front());
      end
      if (dc_ready) begin
        if (dc_q.size() == 0) chk("dc_extra", dc_rdata, '0);
        else chk("dc_rdata", dc_rdata, dc_q.pop_front());
      end
      if (ic_ready || dc_ready)
        chk("overlap", {mem_req, ic_ready & dc_ready}, '0);
    end
  end

  task automatic push_bus(input vec_t v);
    bus_t b;
    if (v.dc) begin
      b.we = v.we;
      b.addr = v.addr & ~32'h3;
      b.wdata = v.wdata;
      b.wstrb = v.we ? v.wstrb : 4'b0000;
      bus_q.push_back(b);
    end else begin
      for (int k = 0; k < 4; k++) begin
        b.we = 1'b0;
        b.addr = (v.addr & ~32'hF) + 32'(4 * k);
        b.wdata = '0;
        b.wstrb = 4'b0000;
        bus_q.push_back(b);
      end
    end
  endtask

  task automatic drive(input vec_t v, output int c);
    @(posedge clk);
    #1;
    c = cyc;
    ack_delay = v.dly;
    push_bus(v);
    if (v.dc) begin
      dc_q.push_back(v.xdat[31:0]);
      dc_valid = 1'b1;
      dc_we = v.we;
      dc_addr = v.addr;
      dc_wdata = v.wdata;
      dc_wstrb = v.wstrb;
    end else begin
      ic_q.push_back(v.xdat);
      ic_valid = 1'b1;
      ic_addr = v.addr;
    end
  endtask

  task automatic wait_rdy(input bit dc, output int at);
    at = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (dc ? dc_ready : ic_ready) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: no %s ready", dc ? "dc" : "ic");
    end
  endtask

  task automatic drop(input bit dc);
    @(posedge clk);
    #1;
    if (dc) dc_valid = 1'b0;
    else ic_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int at;
    int at2;
    bit seen;
    vec_t v;

    bus_mem[32'h200] = 32'hDEADBEEF;
    vecs[0] = '{0, 0, 32'h1C0C, 0, 0, 0, 5,
      {32'h1D0C, 32'h1D08, 32'h1D04, 32'h1D00}};
    vecs[1] = '{0, 0, 32'h40, 0, 0, 2, 13,
      {32'h14C, 32'h148, 32'h144, 32'h140}};
    vecs[2] = '{1, 1, 32'h300, 32'h12345678, 4'b0011, 0, 2,
      128'h0};
    vecs[3] = '{1, 0, 32'h300, 0, 0, 1, 3, 128'h5678};
    vecs[4] = '{1, 1, 32'h304, 32'hAABBCCDD, 4'b1111, 0, 2,
      128'h5678};
    vecs[5] = '{0, 0, 32'hFFFFFFF4, 0, 0, 0, 5,
      {32'hFC, 32'hF8, 32'hF4, 32'hF0}};
    vecs[6] = '{1, 0, 32'h200, 0, 0, 0, 2, 128'hDEADBEEF};
    vecs[7] = '{1, 0, 32'h304, 0, 0, 0, 2, 128'hAABBCCDD};

    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_ready", {ic_ready, dc_ready}, 0);
    chk("rst_ic_line", ic_line, 0);
    chk("rst_dc_rdata", dc_rdata, 0);
    chk("rst_mem_bus", {mem_we, mem_addr, mem_wstrb}, 0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i], c);
      wait_rdy(vecs[i].dc, at);
      chk($sformatf("lat_v%0d", i), at - c, vecs[i].lat);
      drop(vecs[i].dc);
    end

    // reset while beat 2 of a refill is on the bus
    v = '{0, 0, 32'h1C0C, 0, 0, 0, 0, 128'h0};
    @(posedge clk);
    #1;
    ack_delay = 0;
    push_bus(v);
    void'(bus_q.pop_back());
    void'(bus_q.pop_back());
    ic_valid = 1'b1;
    ic_addr = 32'h1C0C;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    ic_valid = 1'b0;
    #1;
    chk("mid_rst_mem_req", mem_req, 0);
    chk("mid_rst_ic_ready", ic_ready, 0);
    chk("mid_rst_ic_line", ic_line, 0);
    chk("mid_rst_dc_rdata", dc_rdata, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= mem_req;
    end
    chk("no_reissue", seen, 0);

    // both clients in the same cycle: DCache first
    @(posedge clk);
    #1;
    c = cyc;
    ack_delay = 0;
    v = '{1, 0, 32'h200, 0, 0, 0, 0, 128'h0};
    push_bus(v);
    v = '{0, 0, 32'h80, 0, 0, 0, 0, 128'h0};
    push_bus(v);
    dc_q.push_back(32'hDEADBEEF);
    ic_q.push_back({32'h18C, 32'h188, 32'h184, 32'h180});
    dc_valid = 1'b1;
    dc_we = 1'b0;
    dc_addr = 32'h200;
    ic_valid = 1'b1;
    ic_addr = 32'h80;
    wait_rdy(1'b1, at);
    chk("both_dc_lat", at - c, 2);
    drop(1'b1);
    wait_rdy(1'b0, at);
    chk("both_ic_lat", at - c, 8);
    drop(1'b0);

    // DCache write raised during a refill waits for ic_ready
    @(posedge clk);
    #1;
    c = cyc;
    ack_delay = 1;
    v = '{0, 0, 32'h500, 0, 0, 0, 0, 128'h0};
    push_bus(v);
    v = '{1, 1, 32'h300, 32'h12345678, 4'b0011, 0, 0, 128'h0};
    push_bus(v);
    ic_q.push_back({32'h60C, 32'h608, 32'h604, 32'h600});
    dc_q.push_back(32'hDEADBEEF);
    ic_valid = 1'b1;
    ic_addr = 32'h500;
    repeat (3) @(posedge clk);
    #1;
    dc_valid = 1'b1;
    dc_we = 1'b1;
    dc_addr = 32'h300;
    dc_wdata = 32'h12345678;
    dc_wstrb = 4'b0011;
    wait_rdy(1'b0, at);
    chk("wr_ic_lat", at - c, 9);
    drop(1'b0);
    wait_rdy(1'b1, at2);
    chk("wr_dc_lat", at2 - c, 13);
    drop(1'b1);
    dc_we = 1'b0;

    // stray ack in IDLE must change nothing
    @(posedge clk);
    #1 stray = 1'b1;
    @(posedge clk);
    #1 stray = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen |= mem_req | ic_ready | dc_ready;
    end
    chk("stray_quiet", seen, 0);
    chk("stray_ic_line", ic_line,
        {32'h60C, 32'h608, 32'h604, 32'h600});
    chk("stray_dc_rdata", dc_rdata, 32'hDEADBEEF);

    chk("bus_q_left", bus_q.size(), 0);
    chk("ic_q_left", ic_q.size(), 0);
    chk("dc_q_left", dc_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
